// File: rtl/sdram_bridge_pkg.sv
// Shared types and default widths for the SDRAM port bridge.
package sdram_bridge_pkg;

  localparam int DEF_ADDR_W  = 23;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The winner is picked combinationally from the
// current requests and the last_grant bit; the one-hot grant and last_grant
// are registered only when the bridge FSM enables a new grant.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic       winner,
  output logic [1:0] grant
);

  logic last_grant;

  // On a tie the client not served last wins; a lone requester always wins.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = ~last_grant;
    end
  end

  // Capture the grant for the whole transaction; last_grant starts at 1 so client 0 wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant      <= 2'b00;
      last_grant <= 1'b1;
    end else if (enable) begin
      grant      <= winner ? 2'b10 : 2'b01;
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/sdram_port_bridge.sv
// Bridges the MixCore (client 0) and record/playback (client 1) word requests
// onto one Avalon-MM master, one transaction at a time.
// Optional readdatavalid watchdog: define SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_port_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                i_clk,
  input  logic                i_rst,

  input  logic                c0_read,
  input  logic                c0_write,
  input  logic [ADDR_W-1:0]   c0_addr,
  input  logic [DATA_W-1:0]   c0_writedata,
  output logic [DATA_W-1:0]   c0_readdata,
  output logic                c0_finished,

  input  logic                c1_read,
  input  logic                c1_write,
  input  logic [ADDR_W-1:0]   c1_addr,
  input  logic [DATA_W-1:0]   c1_writedata,
  output logic [DATA_W-1:0]   c1_readdata,
  output logic                c1_finished,

  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest,

  output logic                o_timeout
);

  state_t            state;
  state_t            state_next;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        req;
  logic              grant_en;
  logic              winner;
  logic [1:0]        grant;
  logic              timeout_hit;
  logic              rd_load;
  logic [DATA_W-1:0] rd_value;

  assign req      = {c1_read | c1_write, c0_read | c0_write};
  assign grant_en = (state == IDLE) && (req != 2'b00);

  rr_arbiter2 u_arb (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .req    (req),
    .enable (grant_en),
    .winner (winner),
    .grant  (grant)
  );

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  // Count cycles spent in WAIT_RD; held at zero elsewhere so every read starts fresh.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT_RD) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = (state == WAIT_RD) && !avm_readdatavalid &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Sticky flag so software can see that the SDRAM controller lost a read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  // Without the watchdog WAIT_RD waits forever; TIMEOUT is referenced only so
  // the parameter stays part of the interface, and the term folds to 0.
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0 & (TIMEOUT != 0);
`endif

  // Advance the FSM state; reset drops any transaction in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one Avalon transaction per grant, no read pipelining.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          state_next = (op_q == OP_RD) ? WAIT_RD : DONE;
        end
      end
      WAIT_RD: begin
        if (avm_readdatavalid || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the granted client's command so it stays stable through back-pressure.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_en) begin
      if (winner) begin
        op_q    <= c1_write ? OP_WR : OP_RD;
        addr_q  <= c1_addr;
        wdata_q <= c1_writedata;
      end else begin
        op_q    <= c0_write ? OP_WR : OP_RD;
        addr_q  <= c0_addr;
        wdata_q <= c0_writedata;
      end
    end
  end

  assign rd_load  = (state == WAIT_RD) && (avm_readdatavalid || timeout_hit);
  assign rd_value = avm_readdatavalid ? avm_readdata : '0;

  // Each client's readdata changes only when its own read completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      c0_readdata <= '0;
      c1_readdata <= '0;
    end else if (rd_load) begin
      if (grant[0]) begin
        c0_readdata <= rd_value;
      end
      if (grant[1]) begin
        c1_readdata <= rd_value;
      end
    end
  end

  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_read       = (state == REQ) && (op_q == OP_RD);
  assign avm_write      = (state == REQ) && (op_q == OP_WR);
  assign avm_byteenable = '1;

  assign c0_finished = (state == DONE) && grant[0];
  assign c1_finished = (state == DONE) && grant[1];

endmodule

// File: tb/tb_sdram_port_bridge.sv
// Directed testbench for sdram_port_bridge. Outputs are sampled 1 ns after the
// rising edge; inputs are changed at the same point.
// Define SDRAM_BRIDGE_TIMEOUT_EN to exercise the watchdog with TIMEOUT = 8.
`timescale 1ns/1ps
module tb_sdram_port_bridge;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              i_clk;
  logic              i_rst;
  logic              c0_read, c0_write, c1_read, c1_write;
  logic [ADDR_W-1:0] c0_addr, c1_addr;
  logic [DATA_W-1:0] c0_writedata, c1_writedata;
  logic [DATA_W-1:0] c0_readdata, c1_readdata;
  logic              c0_finished, c1_finished;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid, avm_waitrequest;
  logic              o_timeout;

  int tests_run;
  int tests_failed;
  logic [DATA_W-1:0] exp_c0_rd;
  logic [DATA_W-1:0] exp_c1_rd;

  sdram_port_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .c0_read           (c0_read),
    .c0_write          (c0_write),
    .c0_addr           (c0_addr),
    .c0_writedata      (c0_writedata),
    .c0_readdata       (c0_readdata),
    .c0_finished       (c0_finished),
    .c1_read           (c1_read),
    .c1_write          (c1_write),
    .c1_addr           (c1_addr),
    .c1_writedata      (c1_writedata),
    .c1_readdata       (c1_readdata),
    .c1_finished       (c1_finished),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .o_timeout         (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tests_run++;
    if ({avm_read, avm_write, c0_finished, c1_finished, o_timeout} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl got %b exp 00000", {avm_read, avm_write, c0_finished, c1_finished, o_timeout});
    end
    tests_run++;
    if ({avm_address, avm_writedata, c0_readdata, c1_readdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data got %h %h %h %h exp all 0", avm_address, avm_writedata, c0_readdata, c1_readdata);
    end
    tests_run++;
    if (avm_byteenable !== 4'hF) begin
      tests_failed++;
      $display("[TB] FAIL reset_byteenable got %h exp f", avm_byteenable);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    c0_write = 1'b1;
    c0_addr = 23'h000010;
    c0_writedata = 32'hDEADBEEF;
    tick();
    tests_run++;
    if ({avm_write, avm_read} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL wr_strobes got %b exp 10", {avm_write, avm_read});
    end
    tests_run++;
    if (avm_address !== 23'h000010 || avm_writedata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL wr_payload got %h/%h exp 000010/deadbeef", avm_address, avm_writedata);
    end
    tests_run++;
    if (c0_finished !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wr_early_finished got %b exp 0", c0_finished);
    end
    tick();
    tests_run++;
    if ({c0_finished, c1_finished, avm_write} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL wr_finished got %b exp 100", {c0_finished, c1_finished, avm_write});
    end
    c0_write = 1'b0;
    tick();
    tests_run++;
    if (c0_finished !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wr_finished_width got %b exp 0", c0_finished);
    end
  endtask

  task automatic test_read_backpressure();
    logic held_ok;
    held_ok = 1'b1;
    avm_waitrequest = 1'b1;
    c1_read = 1'b1;
    c1_addr = 23'h7FFFFF;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (avm_read !== 1'b1 || avm_address !== 23'h7FFFFF || c1_finished !== 1'b0) held_ok = 1'b0;
      tick();
    end
    tests_run++;
    if (held_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rd_hold_under_wait got %b exp 1", held_ok);
    end
    avm_waitrequest = 1'b0;
    tests_run++;
    if (avm_read !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rd_accept_cycle got %b exp 1", avm_read);
    end
    tick();
    tests_run++;
    if ({avm_read, c1_finished} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL rd_wait_state got %b exp 00", {avm_read, c1_finished});
    end
    tick();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h12345678;
    tick();
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'h0;
    exp_c1_rd = 32'h12345678;
    tests_run++;
    if ({c1_finished, c0_finished} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL rd_finished got %b exp 10", {c1_finished, c0_finished});
    end
    tests_run++;
    if (c1_readdata !== exp_c1_rd) begin
      tests_failed++;
      $display("[TB] FAIL rd_c1_readdata got %h exp %h", c1_readdata, exp_c1_rd);
    end
    tests_run++;
    if (c0_readdata !== exp_c0_rd) begin
      tests_failed++;
      $display("[TB] FAIL rd_c0_untouched got %h exp %h", c0_readdata, exp_c0_rd);
    end
    c1_read = 1'b0;
    tick();
    tests_run++;
    if (c1_finished !== 1'b0 || c1_readdata !== exp_c1_rd) begin
      tests_failed++;
      $display("[TB] FAIL rd_after got %b/%h exp 0/%h", c1_finished, c1_readdata, exp_c1_rd);
    end
  endtask

  task automatic test_round_robin();
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] data;
    logic              owner;
    int                k;
    c0_read = 1'b1;
    c0_addr = 23'h000100;
    c1_read = 1'b1;
    c1_addr = 23'h000200;
    for (int t = 0; t < 4; t++) begin
      owner = t[0];
      exp_addr = owner ? 23'h000200 : 23'h000100;
      data = 32'hA0000000 + t;
      k = 0;
      while (avm_read !== 1'b1 && k < 8) begin
        tick();
        k++;
      end
      tests_run++;
      if (avm_read !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL rr_issue_%0d got %b exp 1", t, avm_read);
      end
      tests_run++;
      if (avm_address !== exp_addr) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant_%0d got %h exp %h", t, avm_address, exp_addr);
      end
      tick();
      avm_readdatavalid = 1'b1;
      avm_readdata = data;
      tick();
      avm_readdatavalid = 1'b0;
      if (owner) exp_c1_rd = data;
      else exp_c0_rd = data;
      tests_run++;
      if ({c0_finished, c1_finished} !== (owner ? 2'b01 : 2'b10)) begin
        tests_failed++;
        $display("[TB] FAIL rr_finished_%0d got %b exp %b", t, {c0_finished, c1_finished}, owner ? 2'b01 : 2'b10);
      end
      tests_run++;
      if (c0_readdata !== exp_c0_rd || c1_readdata !== exp_c1_rd) begin
        tests_failed++;
        $display("[TB] FAIL rr_readdata_%0d got %h/%h exp %h/%h", t, c0_readdata, c1_readdata, exp_c0_rd, exp_c1_rd);
      end
      tick();
      if (t == 3) begin
        c0_read = 1'b0;
        c1_read = 1'b0;
      end
    end
    tick();
    tests_run++;
    if ({avm_read, c0_finished, c1_finished} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL rr_quiet got %b exp 000", {avm_read, c0_finished, c1_finished});
    end
  endtask

  task automatic test_read_write_together();
    c0_read = 1'b1;
    c0_write = 1'b1;
    c0_addr = 23'h000055;
    c0_writedata = 32'hCAFEF00D;
    tick();
    tests_run++;
    if ({avm_write, avm_read} !== 2'b10 || avm_writedata !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("[TB] FAIL rw_issue got %b/%h exp 10/cafef00d", {avm_write, avm_read}, avm_writedata);
    end
    tick();
    tests_run++;
    if ({c0_finished, avm_read} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL rw_finished got %b exp 10", {c0_finished, avm_read});
    end
    c0_read = 1'b0;
    c0_write = 1'b0;
    tick();
    tests_run++;
    if (c0_readdata !== exp_c0_rd || avm_read !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rw_readdata got %h/%b exp %h/0", c0_readdata, avm_read, exp_c0_rd);
    end
  endtask

  task automatic test_reset_mid_read();
    c0_read = 1'b1;
    c0_addr = 23'h000020;
    tick();
    tick();
    i_rst = 1'b1;
    c0_read = 1'b0;
    #1;
    exp_c0_rd = '0;
    exp_c1_rd = '0;
    tests_run++;
    if ({avm_read, avm_write, c0_finished, c1_finished, o_timeout} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_ctrl got %b exp 00000", {avm_read, avm_write, c0_finished, c1_finished, o_timeout});
    end
    tests_run++;
    if ({avm_address, c0_readdata, c1_readdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_data got %h %h %h exp 0", avm_address, c0_readdata, c1_readdata);
    end
    tick();
    i_rst = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hBAD0BAD0;
    tick();
    avm_readdatavalid = 1'b0;
    tests_run++;
    if ({c0_finished, c1_finished} !== 2'b00 || c0_readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL rst_stray_valid got %b/%h exp 00/0", {c0_finished, c1_finished}, c0_readdata);
    end
    c0_read = 1'b1;
    c0_addr = 23'h000030;
    tick();
    tests_run++;
    if (avm_read !== 1'b1 || avm_address !== 23'h000030) begin
      tests_failed++;
      $display("[TB] FAIL rst_next_issue got %b/%h exp 1/000030", avm_read, avm_address);
    end
    tick();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0BADCAFE;
    tick();
    avm_readdatavalid = 1'b0;
    exp_c0_rd = 32'h0BADCAFE;
    tests_run++;
    if (c0_finished !== 1'b1 || c0_readdata !== exp_c0_rd) begin
      tests_failed++;
      $display("[TB] FAIL rst_next_done got %b/%h exp 1/%h", c0_finished, c0_readdata, exp_c0_rd);
    end
    c0_read = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    logic quiet_ok;
    quiet_ok = 1'b1;
    c0_read = 1'b1;
    c0_addr = 23'h000040;
    tick();
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      if (c0_finished !== 1'b0 || o_timeout !== 1'b0) quiet_ok = 1'b0;
      tick();
    end
    tests_run++;
    if (quiet_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL to_early got %b exp 1", quiet_ok);
    end
    tests_run++;
    if ({c0_finished, o_timeout} !== 2'b11 || c0_readdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL to_fire got %b/%h exp 11/0", {c0_finished, o_timeout}, c0_readdata);
    end
    c0_read = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({c0_finished, o_timeout} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL to_sticky got %b exp 01", {c0_finished, o_timeout});
    end
`else
    tests_run++;
    if (o_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL to_tied got %b exp 0", o_timeout);
    end
`endif
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    exp_c0_rd = '0;
    exp_c1_rd = '0;
    i_rst = 1'b1;
    c0_read = 1'b0; c0_write = 1'b0; c0_addr = '0; c0_writedata = '0;
    c1_read = 1'b0; c1_write = 1'b0; c1_addr = '0; c1_writedata = '0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    test_reset();
    test_single_write();
    test_read_backpressure();
    test_round_robin();
    test_read_write_together();
    test_reset_mid_read();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdram_port_bridge.md
# sdram_port_bridge

- Sits directly downstream of `MixCore` and the record/playback engine.
- Arbitrates their word-level SDRAM requests (read/write, address, data, one-cycle `finished` pulse) onto a single Avalon-MM master port of the SDRAM controller.
- Handles `waitrequest` back-pressure and pipelined `readdatavalid` returns.
- Presents each client with the simple handshake `MixCore` expects.

## Interface
Clocking: one clock; reset is asynchronous and active-high. Ports `i_clk` / `i_rst`.

Parameters:
- `ADDR_W`, 23: word address width (client and Avalon).
- `DATA_W`, 32: data width.
- `TIMEOUT`, 1024: readdatavalid watchdog limit in cycles. Used only with `SDRAM_BRIDGE_TIMEOUT_EN`.

Clock and reset:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  asynchronous active-high reset.

Client 0 (`MixCore`) and client 1 (record/playback), `N` = 0/1:
- `cN_read`  in  1  read request, level.
- `cN_write`  in  1  write request, level.
- `cN_addr`  in  ADDR_W  word address.
- `cN_writedata`  in  DATA_W  write data.
- `cN_readdata`  out  DATA_W  read result.
- `cN_finished`  out  1  one-cycle completion pulse.

Avalon-MM master:
- `avm_address`  out  ADDR_W.
- `avm_read`  out  1.
- `avm_write`  out  1.
- `avm_writedata`  out  DATA_W.
- `avm_byteenable`  out  DATA_W/8, constant all-ones.
- `avm_readdata`  in  DATA_W.
- `avm_readdatavalid`  in  1.
- `avm_waitrequest`  in  1.

Status:
- `o_timeout`  out  1  sticky watchdog flag.

## Operation
Client protocol:
- Client raises `read` or `write` and holds `addr` and `writedata` stable until it sees `finished`.
- Client must drop the request in the cycle after `finished`, or re-present a new one.
- `read` and `write` asserted together: write wins, read is ignored.

FSM states:
- **IDLE**: if any request is pending, latch the grant, address, data and op; go to REQ.
- **REQ**: drive `avm_read` or `avm_write` with the latched values. Hold them while `avm_waitrequest` = 1. On acceptance, a read goes to WAIT_RD and a write goes to DONE.
- **WAIT_RD**: on `avm_readdatavalid`, register `avm_readdata` into the granted client's `readdata`; go to DONE.
- **DONE**: pulse the granted client's `finished` for exactly one cycle; return to IDLE.

Arbitration:
- Round-robin by a `last_grant` bit.
- When both clients request in IDLE, grant the one not served last.
- A lone requester is always granted.
- `last_grant` resets to 1, so client 0 wins the first tie.

Data and outputs:
- `cN_readdata` holds its value until that client's next completed read; it is not disturbed by the other client.
- Only one transaction is outstanding at a time; no read pipelining.
- A request that drops before it is granted is never issued.

Reset:
- All outputs are 0 (`avm_byteenable` excepted), the FSM is in IDLE and `last_grant` = 1.
- `i_rst` mid-transaction immediately deasserts `avm_read`/`avm_write` and drops the transaction without a `finished` pulse.
- A late `readdatavalid` arriving in IDLE is ignored.

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: `avm_read`/`avm_write` asserted from registers.
- Write with no waitrequest: `finished` in cycle 2.
- Read: `finished` one cycle after the `readdatavalid` cycle. Minimum latency is 3 cycles when `readdatavalid` arrives in cycle 2.
- Each waitrequest cycle adds one cycle.
- Minimum back-to-back issue interval is 3 cycles for writes (REQ, DONE, IDLE).

## Configuration
Macro: `SDRAM_BRIDGE_TIMEOUT_EN`.

Defined:
- A counter runs in WAIT_RD.
- If `TIMEOUT` cycles elapse without `readdatavalid`:
  - `cN_readdata` is loaded with 0;
  - the FSM goes to DONE, so `finished` pulses;
  - `o_timeout` sets and stays set until reset.
- The counter clears on entry to WAIT_RD.

Undefined:
- WAIT_RD waits indefinitely.
- `o_timeout` is tied to 0 and no counter is synthesized.

## Structure
- Package `sdram_bridge_pkg` holds:
  - the FSM state enum (IDLE, REQ, WAIT_RD, DONE);
  - the op enum (OP_RD, OP_WR);
  - default width localparams.
- Sub-module `rr_arbiter2`: two request inputs, `last_grant` register, registered one-hot grant on an enable from the FSM.
- Everything else is in `sdram_port_bridge`.

## Test plan
- **Single write.** c0_write, addr 0x000010, data 0xDEADBEEF, waitrequest 0.
  - Expect `avm_write` with those values in cycle 1.
  - Expect `c0_finished` pulse in cycle 2.
- **Read with back-pressure.** c1_read, addr 0x7FFFFF; waitrequest high 3 cycles; readdatavalid 2 cycles after acceptance with 0x12345678.
  - Expect `c1_readdata` = 0x12345678 and one `c1_finished` pulse.
  - Expect `c0_readdata` unchanged.
- **Simultaneous requests.** Both clients request reads continuously for 4 transactions.
  - Expect grants c0, c1, c0, c1.
  - Expect each `finished` routed only to the owner.
- **Read and write together.** c0_read and c0_write both high.
  - Expect only `avm_write` issued; `avm_read` never asserted.
- **Reset mid-read.** Assert `i_rst` while in WAIT_RD, then deliver a stray `readdatavalid` after reset.
  - Expect all outputs 0 and no `finished`.
  - Expect the next c0 request completes normally.
- **Timeout (macro on).** `TIMEOUT` = 8; read issued and `readdatavalid` never arrives.
  - Expect `c0_finished` with readdata 0 at cycle 8 of WAIT_RD.
  - Expect `o_timeout` = 1 and held.
